fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buf.sv | 33 +++
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and
// default instruction constants.
package fetch_pkg;

    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]         HALT_OP   = 5'b00000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DROP,
        HALT
    } state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry skid buffer that parks a fetched word while decode is stalled.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               drain,
    input  logic               flush,
    input  logic [INSTR_W-1:0] din,
    output logic [INSTR_W-1:0] dout,
    output logic               full
);

    logic [INSTR_W-1:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            data <= din;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    assign dout = data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, request FSM towards a variable-latency memory,
// stall buffer and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [4:0]  HALT_OP   = fetch_pkg::HALT_OP,
    parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted
);
    import fetch_pkg::*;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [15:0] drop_addr;
    logic [15:0] redirect_tgt;
    logic [15:0] buf_word;
    logic        buf_full;
    logic        rsp;
    logic        take_rsp;
    logic        park;
    logic        drain;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == HALT_OP;
    endfunction

    assign redirect_tgt = redirect_pc & 16'hFFFE;
    assign rsp          = (state == REQ) && imem_valid;
    assign take_rsp     = rsp && !redirect && !stall;
    assign park         = rsp && !redirect && stall;
    assign drain        = (state == HOLD) && !redirect && !stall && buf_full;

    fetch_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (park),
        .drain (drain),
        .flush (redirect),
        .din   (imem_rdata),
        .dout  (buf_word),
        .full  (buf_full)
    );

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        halted    = 1'b0;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (redirect)
                    state_nxt = imem_valid ? REQ : DROP;
                else if (imem_valid)
                    state_nxt = stall ? HOLD : (is_halt(imem_rdata) ? HALT : REQ);
            end
            HOLD: begin
                if (redirect)
                    state_nxt = REQ;
                else if (!stall)
                    state_nxt = is_halt(buf_word) ? HALT : REQ;
            end
            DROP: begin
                // The stale request must complete before a new address is issued.
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                if (imem_valid)
                    state_nxt = REQ;
            end
            HALT: begin
                halted = 1'b1;
                if (redirect)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect)
                pc <= redirect_tgt;
            else if (rsp)
                pc <= pc + 16'd2;
            if ((state == REQ) && redirect && !imem_valid)
                drop_addr <= pc;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= NOP_INSTR;
            pc_plus2    <= 16'h0000;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (take_rsp) begin
            instr       <= imem_rdata;
            pc_plus2    <= pc + 16'd2;
            instr_valid <= 1'b1;
        end else if (drain) begin
            // pc already advanced past the buffered word when it was parked.
            instr       <= buf_word;
            pc_plus2    <= pc;
            instr_valid <= 1'b1;
        end else if (!stall) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against an in-order fetch-stream reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;

    int ncmp = 0;
    int nerr = 0;

    int          lat_fix  = 0;
    bit          rand_lat = 1'b0;
    int          lat_r    = 0;
    int          wcnt     = 0;
    bit          mode     = 1'b0;
    bit          halt_en  = 1'b0;
    logic [15:0] halt_addr = 16'h0000;

    localparam logic [15:0] NOP = 16'h0800;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    // Memory contents: addr|0x4000, or a scrambled word whose opcode is never HALT.
    function automatic logic [15:0] word(input logic [15:0] a, input bit m,
                                         input bit hen, input logic [15:0] ha);
        if (hen && a == ha) return 16'h0000;
        if (m) return (16'h8000 | (a >> 1)) ^ 16'h0123;
        return a | 16'h4000;
    endfunction

    assign imem_valid = imem_req && (wcnt >= (rand_lat ? lat_r : lat_fix));
    assign imem_rdata = word(imem_addr, mode, halt_en, halt_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else if (imem_req && !imem_valid) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (imem_valid) lat_r <= int'($urandom_range(0, 3));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_instr"}, 32'(instr), 32'(NOP));
        check({tag, "_pp2"},   32'(pc_plus2), 32'h0);
        check({tag, "_vld"},   32'(instr_valid), 32'h0);
        check({tag, "_halt"},  32'(halted), 32'h0);
        check({tag, "_req"},   32'(imem_req), 32'h0);
        check({tag, "_addr"},  32'(imem_addr), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_reset(tag);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_addr(input logic [15:0] a, input string tag);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'({imem_req, imem_addr}), 32'({1'b1, a}));
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!instr_valid && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(instr_valid), 32'h1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_pc;
        int          ncons;
        int          n;
        logic        prev_redirect, prev_stall, prev_req, prev_vld, prev_v;
        logic [15:0] prev_addr, prev_instr, prev_pp2;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        #12;

        // Zero-wait streaming and a 3-cycle stall absorbed by the buffer.
        do_reset("rst0");
        check("idle_req", 32'(imem_req), 32'h0);
        tick(); check("b_req", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));
        tick(); check("c_addr", 32'(imem_addr), 32'h2);
        check("c_instr", 32'(instr), 32'h4000);
        check("c_pp2", 32'(pc_plus2), 32'h2);
        check("c_vld", 32'(instr_valid), 32'h1);
        tick(); check("d_addr", 32'(imem_addr), 32'h4);
        check("d_instr", 32'(instr), 32'h4002);
        check("d_pp2", 32'(pc_plus2), 32'h4);
        tick(); check("e_addr", 32'(imem_addr), 32'h6);
        check("e_instr", 32'(instr), 32'h4004);
        stall = 1'b1;
        tick(); check("f_req", 32'(imem_req), 32'h0);
        check("f_instr", 32'(instr), 32'h4004);
        tick(); check("g_req", 32'(imem_req), 32'h0);
        check("g_hold", 32'({instr_valid, instr}), 32'({1'b1, 16'h4004}));
        tick(); check("h_req", 32'(imem_req), 32'h0);
        check("h_instr", 32'(instr), 32'h4004);
        stall = 1'b0;
        tick(); check("i_instr", 32'(instr), 32'h4006);
        check("i_pp2", 32'(pc_plus2), 32'h8);
        check("i_addr", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0008}));
        tick(); check("j_instr", 32'(instr), 32'h4008);
        check("j_pp2", 32'(pc_plus2), 32'hA);

        // Redirect while a 3-cycle-latency request is outstanding.
        lat_fix = 3;
        do_reset("rst1");
        wait_addr(16'h0006, "wait_6");
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick(); redirect = 1'b0;
        check("drop_vld", 32'(instr_valid), 32'h0);
        check("drop_addr", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0006}));
        wait_addr(16'h0100, "wait_100");
        check("drop_nop", 32'({instr_valid, instr}), 32'({1'b0, NOP}));
        wait_vld("wait_v100");
        check("t100_instr", 32'(instr), 32'h4100);
        check("t100_pp2", 32'(pc_plus2), 32'h0102);

        // HALT stops fetch; a redirect resumes it.
        lat_fix = 0; halt_en = 1'b1; halt_addr = 16'h0106;
        n = 0;
        while (!(instr_valid && instr == 16'h0000) && n < 50) begin
            tick();
            n++;
        end
        check("halt_seen", 32'({instr_valid, instr}), 32'({1'b1, 16'h0000}));
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_req", 32'(imem_req), 32'h0);
        check("halt_pp2", 32'(pc_plus2), 32'h0108);
        tick(); check("halt_nop", 32'({halted, imem_req, instr_valid}), 32'b100);
        tick(); tick(); check("halt_stay", 32'({halted, imem_req}), 32'b10);
        halt_en = 1'b0; redirect = 1'b1; redirect_pc = 16'h0020;
        tick(); redirect = 1'b0;
        check("resume_halt", 32'(halted), 32'h0);
        check("resume_addr", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0020}));
        tick(); check("resume_instr", 32'({instr_valid, instr}), 32'({1'b1, 16'h4020}));

        // Redirect and stall together with a word parked in the buffer.
        stall = 1'b1;
        tick(); check("park_req", 32'(imem_req), 32'h0);
        check("park_instr", 32'(instr), 32'h4020);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick(); redirect = 1'b0; stall = 1'b0;
        check("flush_vld", 32'({instr_valid, instr}), 32'({1'b0, NOP}));
        check("flush_addr", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0040}));
        tick(); check("flush_instr", 32'(instr), 32'h4040);
        check("flush_pp2", 32'(pc_plus2), 32'h0042);

        // Wrap at the top of the address space; bit 0 of the target ignored.
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick(); redirect = 1'b0;
        check("wrap_addr0", 32'({imem_req, imem_addr}), 32'({1'b1, 16'hFFFE}));
        tick(); check("wrap_addr1", 32'(imem_addr), 32'h0000);
        check("wrap_instr", 32'(instr), 32'hFFFE);
        check("wrap_pp2", 32'(pc_plus2), 32'h0000);

        // Asynchronous reset while waiting out a stale response.
        lat_fix = 3;
        redirect = 1'b1; redirect_pc = 16'h0200;
        tick(); redirect = 1'b0;
        check("pre_rst_drop", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));
        rst_n = 1'b0;
        #1;
        chk_reset("rst_drop");
        tick();
        rst_n = 1'b1;

        // Randomized run: stream of consumed words must follow program order.
        mode = 1'b1; rand_lat = 1'b1;
        do_reset("rst2");
        exp_pc = 16'h0000; ncons = 0;
        prev_redirect = 1'b0; prev_stall = 1'b0; prev_req = 1'b0; prev_vld = 1'b0;
        prev_v = 1'b0; prev_addr = 16'h0; prev_instr = NOP; prev_pp2 = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            if (prev_redirect)
                check("r_flush", 32'({instr_valid, instr}), 32'({1'b0, NOP}));
            else if (prev_stall)
                check("r_hold", 32'({instr_valid, pc_plus2, instr}) ,
                      32'({prev_v, prev_pp2, prev_instr}));
            if (!instr_valid)
                check("r_nop", 32'(instr), 32'(NOP));
            if (prev_req && !prev_vld)
                check("r_addr_hold", 32'({imem_req, imem_addr}), 32'({1'b1, prev_addr}));
            check("r_halted", 32'(halted), 32'h0);

            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            #1;
            if (instr_valid && !stall && !redirect) begin
                check("r_instr", 32'(instr), 32'(word(exp_pc, 1'b1, 1'b0, 16'h0)));
                check("r_pp2", 32'(pc_plus2), 32'(exp_pc + 16'd2));
                exp_pc = exp_pc + 16'd2;
                ncons++;
            end
            if (redirect) exp_pc = redirect_pc & 16'hFFFE;

            prev_redirect = redirect; prev_stall = stall;
            prev_req = imem_req; prev_vld = imem_valid; prev_addr = imem_addr;
            prev_v = instr_valid; prev_instr = instr; prev_pp2 = pc_plus2;
            tick();
        end
        stall = 1'b0; redirect = 1'b0;
        check("r_progress", 32'(ncons > 200), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
